// File: rtl/march_cminus_sequencer.sv
// March C- sequencer: drives a single-port SRAM through w0/r0w1/r1w0 (up), r0w1/r1w0/r0 (down),
// checking each read one cycle later and logging done, sticky fail, first-fail location and error count.
module march_cminus_sequencer #(
   parameter int                    ADDR_WIDTH    = 8,
   parameter int                    DATA_WIDTH    = 8,
   parameter logic [DATA_WIDTH-1:0] BG_PATTERN    = '0,
   parameter int                    ERR_CNT_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [DATA_WIDTH-1:0]    mem_rdata,
   output logic [ADDR_WIDTH-1:0]    mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   output logic                     mem_we,
   output logic                     busy,
   output logic                     done,
   output logic                     fail,
   output logic [ADDR_WIDTH-1:0]    first_fail_addr,
   output logic [2:0]               first_fail_elem,
   output logic [ERR_CNT_WIDTH-1:0] err_count
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   localparam logic [ADDR_WIDTH-1:0]    ADDR_MAX = '1;
   localparam logic [ADDR_WIDTH-1:0]    ADDR_ONE = ADDR_WIDTH'(1);
   localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX  = '1;
   localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE  = ERR_CNT_WIDTH'(1);

   state_t                   state_q, state_d;
   logic [2:0]               elem_q, elem_d;
   logic                     op_q, op_d;
   logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
   logic                     cmp_valid_q, cmp_valid_d;
   logic [DATA_WIDTH-1:0]    cmp_exp_q, cmp_exp_d;
   logic [ADDR_WIDTH-1:0]    cmp_addr_q, cmp_addr_d;
   logic [2:0]               cmp_elem_q, cmp_elem_d;
   logic                     fail_q, fail_d;
   logic [ADDR_WIDTH-1:0]    ffa_q, ffa_d;
   logic [2:0]               ffe_q, ffe_d;
   logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
   logic                     done_q, done_d;

   logic                     is_down, is_read, data_one, last_op, last_addr;
   logic [DATA_WIDTH-1:0]    op_data;

   // Element decode: E0/E5 have one op; op 0 of E1..E5 is the read, op 1 the write.
   always_comb begin
      is_down   = (elem_q >= 3'd3);
      is_read   = (op_q == 1'b0) && (elem_q != 3'd0);
      data_one  = op_q ? ((elem_q == 3'd1) || (elem_q == 3'd3))
                       : ((elem_q == 3'd2) || (elem_q == 3'd4));
      op_data   = data_one ? ~BG_PATTERN : BG_PATTERN;
      last_op   = op_q || (elem_q == 3'd0) || (elem_q == 3'd5);
      last_addr = is_down ? (addr_q == '0) : (addr_q == ADDR_MAX);
   end

   always_comb begin
      state_d     = state_q;
      elem_d      = elem_q;
      op_d        = op_q;
      addr_d      = addr_q;
      cmp_valid_d = 1'b0;
      cmp_exp_d   = cmp_exp_q;
      cmp_addr_d  = cmp_addr_q;
      cmp_elem_d  = cmp_elem_q;
      fail_d      = fail_q;
      ffa_d       = ffa_q;
      ffe_d       = ffe_q;
      err_d       = err_q;
      done_d      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_we      = 1'b0;

      if (cmp_valid_q && (mem_rdata != cmp_exp_q)) begin
         fail_d = 1'b1;
         if (err_q != ERR_MAX) err_d = err_q + ERR_ONE;
         if (!fail_q) begin
            ffa_d = cmp_addr_q;
            ffe_d = cmp_elem_q;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               elem_d  = 3'd0;
               op_d    = 1'b0;
               addr_d  = '0;
               fail_d  = 1'b0;
               ffa_d   = '0;
               ffe_d   = 3'd0;
               err_d   = '0;
            end
         end
         S_RUN: begin
            mem_addr  = addr_q;
            mem_we    = !is_read;
            mem_wdata = op_data;
            if (is_read) begin
               cmp_valid_d = 1'b1;
               cmp_exp_d   = op_data;
               cmp_addr_d  = addr_q;
               cmp_elem_d  = elem_q;
            end
            if (!last_op) begin
               op_d = 1'b1;
            end else begin
               op_d = 1'b0;
               if (!last_addr) begin
                  addr_d = is_down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
               end else if (elem_q == 3'd5) begin
                  state_d = S_DRAIN;
               end else begin
                  // E2 ends at N-1 and E3 starts there, so the direction flip lands on a boundary.
                  elem_d = elem_q + 3'd1;
                  addr_d = (elem_q >= 3'd2) ? ADDR_MAX : '0;
               end
            end
         end
         S_DRAIN: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            elem_d  = 3'd0;
            addr_d  = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         elem_q      <= 3'd0;
         op_q        <= 1'b0;
         addr_q      <= '0;
         cmp_valid_q <= 1'b0;
         cmp_exp_q   <= '0;
         cmp_addr_q  <= '0;
         cmp_elem_q  <= 3'd0;
         fail_q      <= 1'b0;
         ffa_q       <= '0;
         ffe_q       <= 3'd0;
         err_q       <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         elem_q      <= elem_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         cmp_valid_q <= cmp_valid_d;
         cmp_exp_q   <= cmp_exp_d;
         cmp_addr_q  <= cmp_addr_d;
         cmp_elem_q  <= cmp_elem_d;
         fail_q      <= fail_d;
         ffa_q       <= ffa_d;
         ffe_q       <= ffe_d;
         err_q       <= err_d;
         done_q      <= done_d;
      end
   end

   assign busy            = (state_q != S_IDLE);
   assign done            = done_q;
   assign fail            = fail_q;
   assign first_fail_addr = ffa_q;
   assign first_fail_elem = ffe_q;
   assign err_count       = err_q;

endmodule

// File: tb/tb_march_cminus_sequencer.sv
// Directed bench for march_cminus_sequencer: fault table on N=256, op trace on N=4,
// counter saturation, N=2 sequencing, reset mid-run and start handling.
module tb_march_cminus_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- dut0: defaults, faulty SRAM model ----------------
   logic       start0 = 1'b0;
   logic [7:0] rdata0, addr0, wdata0, ffa0, err0;
   logic       we0, busy0, done0, fail0;
   logic [2:0] ffe0;
   logic [7:0] mem0 [256];
   logic [7:0] ra0 = 8'h00;
   logic [7:0] f_addr = 8'h00, f_or = 8'h00, f_and = 8'hFF;

   always @(posedge clk) begin
      if (we0) mem0[addr0] <= wdata0;
      ra0 <= addr0;
   end
   assign rdata0 = (ra0 == f_addr) ? ((mem0[ra0] | f_or) & f_and) : mem0[ra0];

   march_cminus_sequencer dut0 (
      .clk(clk), .rst(rst), .start(start0), .mem_rdata(rdata0),
      .mem_addr(addr0), .mem_wdata(wdata0), .mem_we(we0), .busy(busy0), .done(done0),
      .fail(fail0), .first_fail_addr(ffa0), .first_fail_elem(ffe0), .err_count(err0));

   // ---------------- dut1: ADDR_WIDTH=2 ----------------
   logic       start1 = 1'b0;
   logic [7:0] rdata1, wdata1, err1;
   logic [1:0] addr1, ffa1;
   logic       we1, busy1, done1, fail1;
   logic [2:0] ffe1;
   logic [7:0] mem1 [4];
   logic [1:0] ra1 = 2'd0;

   always @(posedge clk) begin
      if (we1) mem1[addr1] <= wdata1;
      ra1 <= addr1;
   end
   assign rdata1 = mem1[ra1];

   march_cminus_sequencer #(.ADDR_WIDTH(2)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .mem_rdata(rdata1),
      .mem_addr(addr1), .mem_wdata(wdata1), .mem_we(we1), .busy(busy1), .done(done1),
      .fail(fail1), .first_fail_addr(ffa1), .first_fail_elem(ffe1), .err_count(err1));

   // ---------------- dut2: ERR_CNT_WIDTH=2, every word reads 0x5A ----------------
   logic       start2 = 1'b0;
   logic [7:0] rdata2, addr2, wdata2, ffa2;
   logic [1:0] err2;
   logic       we2, busy2, done2, fail2;
   logic [2:0] ffe2;
   assign rdata2 = 8'h5A;

   march_cminus_sequencer #(.ERR_CNT_WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .mem_rdata(rdata2),
      .mem_addr(addr2), .mem_wdata(wdata2), .mem_we(we2), .busy(busy2), .done(done2),
      .fail(fail2), .first_fail_addr(ffa2), .first_fail_elem(ffe2), .err_count(err2));

   // ---------------- dut3: ADDR_WIDTH=1 ----------------
   logic       start3 = 1'b0;
   logic [7:0] rdata3, wdata3, err3;
   logic [0:0] addr3, ffa3;
   logic       we3, busy3, done3, fail3;
   logic [2:0] ffe3;
   logic [7:0] mem3 [2];
   logic [0:0] ra3 = 1'b0;

   always @(posedge clk) begin
      if (we3) mem3[addr3] <= wdata3;
      ra3 <= addr3;
   end
   assign rdata3 = mem3[ra3];

   march_cminus_sequencer #(.ADDR_WIDTH(1)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .mem_rdata(rdata3),
      .mem_addr(addr3), .mem_wdata(wdata3), .mem_we(we3), .busy(busy3), .done(done3),
      .fail(fail3), .first_fail_addr(ffa3), .first_fail_elem(ffe3), .err_count(err3));

   // ---------------- vector tables ----------------
   typedef struct {
      logic [7:0] f_addr;
      logic [7:0] f_or;
      logic [7:0] f_and;
      logic       exp_fail;
      logic [7:0] exp_ffa;
      logic [2:0] exp_ffe;
      logic [7:0] exp_err;
   } fault_vec_t;

   typedef struct {
      logic [1:0] addr;
      logic       we;
      logic [7:0] wdata;
   } trace_vec_t;

   fault_vec_t fv [5];
   trace_vec_t tv [40];
   int ta [40];
   int tw [40];
   int td [40];

   // One full run of dut0 with fault vector s; poke pulses start while busy.
   task automatic run0(input int s, input bit poke);
      int done_at, done_n, busy_n;
      f_addr  = fv[s].f_addr;
      f_or    = fv[s].f_or;
      f_and   = fv[s].f_and;
      done_at = -1;
      done_n  = 0;
      busy_n  = 0;
      @(negedge clk);
      start0 = 1'b1;
      for (int c = 1; c <= 2600; c++) begin
         @(negedge clk);
         start0 = poke && (c == 100);
         if (busy0) busy_n++;
         if (done0) begin
            done_n++;
            if (done_at < 0) done_at = c;
         end
         if (s == 0 && !poke && c <= 3) begin
            check("first_ops_addr", addr0, c - 1);
            check("first_ops_we", we0, 1);
            check("first_ops_wdata", wdata0, 8'h00);
         end
         if (poke && c == 101) check("start_while_busy_addr", addr0, 8'd100);
      end
      check("done_cycle", done_at, 2562);
      check("done_pulses", done_n, 1);
      check("busy_cycles", busy_n, 2561);
      check("fail", fail0, fv[s].exp_fail);
      check("first_fail_addr", ffa0, fv[s].exp_ffa);
      check("first_fail_elem", ffe0, fv[s].exp_ffe);
      check("err_count", err0, fv[s].exp_err);
   endtask

   initial begin
      int done_at, done_n;

      fv[0] = '{8'h00, 8'h00, 8'hFF, 1'b0, 8'h00, 3'd0, 8'd0};
      fv[1] = '{8'h05, 8'h01, 8'hFF, 1'b1, 8'h05, 3'd1, 8'd3};
      fv[2] = '{8'hFE, 8'h00, 8'h7F, 1'b1, 8'hFE, 3'd2, 8'd2};
      fv[3] = '{8'h00, 8'h80, 8'hFF, 1'b1, 8'h00, 3'd1, 8'd3};
      fv[4] = '{8'hFF, 8'h00, 8'hFE, 1'b1, 8'hFF, 3'd2, 8'd2};

      ta = '{0,1,2,3, 0,0,1,1,2,2,3,3, 0,0,1,1,2,2,3,3, 3,3,2,2,1,1,0,0, 3,3,2,2,1,1,0,0, 3,2,1,0};
      tw = '{1,1,1,1, 0,1,0,1,0,1,0,1, 0,1,0,1,0,1,0,1, 0,1,0,1,0,1,0,1, 0,1,0,1,0,1,0,1, 0,0,0,0};
      td = '{0,0,0,0, 0,1,0,1,0,1,0,1, 1,0,1,0,1,0,1,0, 0,1,0,1,0,1,0,1, 1,0,1,0,1,0,1,0, 0,0,0,0};
      for (int i = 0; i < 40; i++) begin
         tv[i].addr  = 2'(ta[i]);
         tv[i].we    = (tw[i] != 0);
         tv[i].wdata = (td[i] != 0) ? 8'hFF : 8'h00;
      end

      // reset state
      repeat (3) @(negedge clk);
      check("rst_busy", busy0, 0);
      check("rst_done", done0, 0);
      check("rst_we", we0, 0);
      check("rst_addr", addr0, 0);
      check("rst_wdata", wdata0, 0);
      check("rst_fail", fail0, 0);
      check("rst_ffa", ffa0, 0);
      check("rst_ffe", ffe0, 0);
      check("rst_err", err0, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int s = 0; s < 5; s++) run0(s, 1'b0);
      run0(0, 1'b1);

      // reset mid-run: rst high during cycle 700
      f_addr = 8'h05; f_or = 8'h01; f_and = 8'hFF;
      @(negedge clk);
      start0 = 1'b1;
      for (int c = 1; c <= 699; c++) begin
         @(negedge clk);
         start0 = 1'b0;
      end
      check("fail_before_rst", fail0, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", busy0, 0);
      check("midrst_we", we0, 0);
      check("midrst_fail", fail0, 0);
      check("midrst_err", err0, 0);
      check("midrst_addr", addr0, 0);
      done_n = 0;
      for (int c = 0; c < 50; c++) begin
         if (done0) done_n++;
         @(negedge clk);
      end
      check("midrst_no_done", done_n, 0);
      run0(0, 1'b0);

      // dut1: cycle-accurate 40-op trace, start held high through done
      @(negedge clk);
      start1 = 1'b1;
      for (int c = 1; c <= 43; c++) begin
         @(negedge clk);
         if (c <= 40) begin
            check("trace_addr", addr1, tv[c-1].addr);
            check("trace_we", we1, tv[c-1].we);
            check("trace_wdata", wdata1, tv[c-1].wdata);
         end
      end
      check("held_start_restart_busy", busy1, 1);
      check("held_start_restart_addr", addr1, 0);
      check("held_start_restart_we", we1, 1);
      start1 = 1'b0;
      done_at = -1;
      for (int c = 0; c < 60 && done_at < 0; c++) begin
         @(negedge clk);
         if (done1) done_at = c;
      end
      check("n4_restart_done_seen", (done_at >= 0), 1);
      check("n4_fail", fail1, 0);

      // dut1 drain/done cycles on a fresh run
      @(negedge clk);
      start1 = 1'b1;
      for (int c = 1; c <= 42; c++) begin
         @(negedge clk);
         start1 = 1'b0;
         if (c == 41) begin
            check("n4_drain_busy", busy1, 1);
            check("n4_drain_we", we1, 0);
            check("n4_drain_done", done1, 0);
         end
      end
      check("n4_done", done1, 1);
      check("n4_done_busy", busy1, 0);

      // dut2: counter saturation
      @(negedge clk);
      start2 = 1'b1;
      done_at = -1;
      for (int c = 1; c <= 2600; c++) begin
         @(negedge clk);
         start2 = 1'b0;
         if (done2 && done_at < 0) done_at = c;
      end
      check("sat_done_cycle", done_at, 2562);
      check("sat_fail", fail2, 1);
      check("sat_ffa", ffa2, 8'h00);
      check("sat_ffe", ffe2, 1);
      check("sat_err", err2, 3);

      // dut3: N=2
      @(negedge clk);
      start3 = 1'b1;
      done_at = -1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         start3 = 1'b0;
         if (c == 3) begin
            check("n2_e1_addr", addr3, 0);
            check("n2_e1_we", we3, 0);
         end
         if (c == 11) begin
            check("n2_e3_addr", addr3, 1);
            check("n2_e3_we", we3, 0);
            check("n2_e3_wdata", wdata3, 8'h00);
         end
         if (done3 && done_at < 0) done_at = c;
      end
      check("n2_done_cycle", done_at, 22);
      check("n2_fail", fail3, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
